exe_issue_stage: RTL and testbench

Issue end of the execute-stage ALU interface. It takes decoded-stage instructions with register-file read data and the PC, and builds the ALU operands op1/op2, the one-hot alu_info, the branch/jump select and is_word_opt. Results are held in a 2-entry valid/ready skid buffer so exe can stall without a combinational ready path back to decode.

---
 rtl/exe_issue_stage_pkg.sv | 92 +++++++++
 rtl/exe_issue_stage_decode.sv | 127 ++++++++++++
 rtl/exe_issue_stage.sv | 107 ++++++++++
 tb/tb_exe_issue_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_issue_stage_pkg.sv
// Shared constants, entry layout and ALU select helpers for the execute issue stage.
package exe_issue_stage_pkg;

  localparam int REG_BUS = 64;

  localparam int ALU_W    = 10;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_XOR  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_AND  = 6;
  localparam int ALU_SLL  = 7;
  localparam int ALU_SRL  = 8;
  localparam int ALU_SRA  = 9;

  localparam int BJ_W    = 8;
  localparam int BJ_BEQ  = 0;
  localparam int BJ_BNE  = 1;
  localparam int BJ_BLT  = 2;
  localparam int BJ_BGE  = 3;
  localparam int BJ_BLTU = 4;
  localparam int BJ_BGEU = 5;
  localparam int BJ_JALR = 6;
  localparam int BJ_JAL  = 7;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [REG_BUS-1:0] op1;
    logic [REG_BUS-1:0] op2;
    logic [ALU_W-1:0]   alu_info;
    logic [BJ_W-1:0]    bj_sel;
    logic               is_word_opt;
    logic [REG_BUS-1:0] imm;
    logic [REG_BUS-1:0] pc;
    logic               illegal;
  } issue_entry_t;

  function automatic logic [ALU_W-1:0] alu_bit(input int idx);
    return ALU_W'(1) << idx;
  endfunction

  function automatic logic [BJ_W-1:0] bj_bit(input int idx);
    return BJ_W'(1) << idx;
  endfunction

  // ALU op selected by funct3 when funct7 carries no alternate-op bit.
  function automatic logic [ALU_W-1:0] base_alu(input logic [2:0] f3);
    logic [ALU_W-1:0] r;
    case (f3)
      F3_ADD:  r = alu_bit(ALU_ADD);
      F3_SLL:  r = alu_bit(ALU_SLL);
      F3_SLT:  r = alu_bit(ALU_SLT);
      F3_SLTU: r = alu_bit(ALU_SLTU);
      F3_XOR:  r = alu_bit(ALU_XOR);
      F3_SR:   r = alu_bit(ALU_SRL);
      F3_OR:   r = alu_bit(ALU_OR);
      default: r = alu_bit(ALU_AND);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exe_issue_stage_decode.sv
// issue_decode: combinational RV64I decode of inst/pc/register data into an issue entry.
module issue_decode
  import exe_issue_stage_pkg::*;
(
  input  logic [31:0]        inst,
  input  logic [REG_BUS-1:0] pc,
  input  logic [REG_BUS-1:0] rs1,
  input  logic [REG_BUS-1:0] rs2,
  output issue_entry_t       entry
);

  logic [6:0]         opcode;
  logic [6:0]         funct7;
  logic [2:0]         funct3;
  logic [REG_BUS-1:0] imm_i, imm_u, imm_j, imm_b;
  logic               w_op, base_ok, alt_ok, legal;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = {{52{inst[31]}}, inst[31:20]};
  assign imm_u  = {{32{inst[31]}}, inst[31:12], 12'b0};
  assign imm_j  = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_b  = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_op   = (opcode == OPC_OP_32) || (opcode == OPC_OP_IMM_32);
  // 64-bit shift immediates borrow funct7[0] as shamt[5], so only funct7[6:1] is decoded there.
  assign base_ok = w_op ? (funct7 == F7_BASE) : (inst[31:26] == F7_BASE[6:1]);
  assign alt_ok  = w_op ? (funct7 == F7_ALT)  : (inst[31:26] == F7_ALT[6:1]);

  always_comb begin
    entry    = '0;
    entry.pc = pc;
    legal    = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_32: begin
        entry.op1         = rs1;
        entry.op2         = rs2;
        entry.is_word_opt = w_op;
        if (funct7 == F7_BASE) begin
          entry.alu_info = base_alu(funct3);
          legal = !w_op || (funct3 inside {F3_ADD, F3_SLL, F3_SR});
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          entry.alu_info = alu_bit(ALU_SUB);
          legal = 1'b1;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          entry.alu_info = alu_bit(ALU_SRA);
          legal = 1'b1;
        end
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        entry.op1         = rs1;
        entry.op2         = imm_i;
        entry.imm         = imm_i;
        entry.is_word_opt = w_op;
        if (funct3 == F3_SLL || funct3 == F3_SR) begin
          entry.op2 = w_op ? {59'b0, inst[24:20]} : {58'b0, inst[25:20]};
          if (base_ok) begin
            entry.alu_info = base_alu(funct3);
            legal = 1'b1;
          end else if (alt_ok && funct3 == F3_SR) begin
            entry.alu_info = alu_bit(ALU_SRA);
            legal = 1'b1;
          end
        end else begin
          entry.alu_info = base_alu(funct3);
          legal = !w_op || (funct3 == F3_ADD);
        end
      end
      OPC_LUI: begin
        entry.op2      = imm_u;
        entry.imm      = imm_u;
        entry.alu_info = alu_bit(ALU_ADD);
        legal = 1'b1;
      end
      OPC_AUIPC: begin
        entry.op1      = pc;
        entry.op2      = imm_u;
        entry.imm      = imm_u;
        entry.alu_info = alu_bit(ALU_ADD);
        legal = 1'b1;
      end
      OPC_JAL: begin
        entry.op1      = pc;
        entry.op2      = 64'd4;
        entry.imm      = imm_j;
        entry.alu_info = alu_bit(ALU_ADD);
        entry.bj_sel   = bj_bit(BJ_JAL);
        legal = 1'b1;
      end
      OPC_JALR: begin
        entry.op1      = pc;
        entry.op2      = 64'd4;
        entry.imm      = imm_i;
        entry.alu_info = alu_bit(ALU_ADD);
        entry.bj_sel   = bj_bit(BJ_JALR);
        legal = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        entry.op1 = rs1;
        entry.op2 = rs2;
        entry.imm = imm_b;
        legal = 1'b1;
        case (funct3)
          F3_BEQ:  begin entry.alu_info = alu_bit(ALU_XOR);  entry.bj_sel = bj_bit(BJ_BEQ);  end
          F3_BNE:  begin entry.alu_info = alu_bit(ALU_XOR);  entry.bj_sel = bj_bit(BJ_BNE);  end
          F3_BLT:  begin entry.alu_info = alu_bit(ALU_SLT);  entry.bj_sel = bj_bit(BJ_BLT);  end
          F3_BGE:  begin entry.alu_info = alu_bit(ALU_SLT);  entry.bj_sel = bj_bit(BJ_BGE);  end
          F3_BLTU: begin entry.alu_info = alu_bit(ALU_SLTU); entry.bj_sel = bj_bit(BJ_BLTU); end
          F3_BGEU: begin entry.alu_info = alu_bit(ALU_SLTU); entry.bj_sel = bj_bit(BJ_BGEU); end
          default: legal = 1'b0;
        endcase
      end
      default: ;
    endcase
    // Word right shifts must see a clean 32-bit source; the ALU shifts all 64 bits.
    if (legal && w_op && entry.alu_info == alu_bit(ALU_SRL))
      entry.op1 = {32'b0, rs1[31:0]};
    if (legal && w_op && entry.alu_info == alu_bit(ALU_SRA))
      entry.op1 = {{32{rs1[31]}}, rs1[31:0]};
    if (!legal) begin
      entry         = '0;
      entry.pc      = pc;
      entry.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/exe_issue_stage.sv
// Execute issue stage: decode into a 2-entry in-order valid/ready skid buffer.
// Optional stall counter output enabled by defining ISSUE_STALL_CNT_EN.
module exe_issue_stage
  import exe_issue_stage_pkg::*;
#(
  parameter int XLEN  = REG_BUS,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  op1,
  output logic [XLEN-1:0]  op2,
  output logic [ALU_W-1:0] alu_info,
  output logic [BJ_W-1:0]  bj_sel,
  output logic             is_word_opt,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  out_pc,
  output logic             illegal
`ifdef ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // in_ready comes only from the registered count, never from out_ready.
  issue_entry_t dec_entry, head_q, skid_q;
  logic [1:0]   count;
  logic         push, pop;

  issue_decode u_decode (
    .inst  (in_inst),
    .pc    (in_pc),
    .rs1   (rs1_data),
    .rs2   (rs2_data),
    .entry (dec_entry)
  );

  assign in_ready  = (count < 2'(DEPTH));
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // head_q always drives the outputs, so it holds its value while empty or stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= 2'd0;
      head_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_q <= dec_entry;
            count  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= dec_entry;
          end else if (push) begin
            skid_q <= dec_entry;
            count  <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_q <= skid_q;
            count  <= 2'd1;
          end
        end
      endcase
    end
  end

  assign op1         = head_q.op1;
  assign op2         = head_q.op2;
  assign alu_info    = head_q.alu_info;
  assign bj_sel      = head_q.bj_sel;
  assign is_word_opt = head_q.is_word_opt;
  assign imm         = head_q.imm;
  assign out_pc      = head_q.pc;
  assign illegal     = head_q.illegal;

`ifdef ISSUE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_exe_issue_stage.sv
// Bench for exe_issue_stage: directed steps, then random traffic against a queue-based model.
module tb_exe_issue_stage;

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [9:0]  alu;
    logic [7:0]  bj;
    logic        w;
    logic [63:0] imm;
    logic [63:0] pc;
    logic        ill;
    logic        chk_imm;
  } exp_t;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc, rs1_data, rs2_data, op1, op2, imm, out_pc;
  logic [9:0]  alu_info;
  logic [7:0]  bj_sel;
  logic        is_word_opt, illegal;
`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] stall_m;
`endif

  int   checks, errors;
  exp_t exp_q[$];
  exp_t shown;

  string rr_names[8]   = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
  string alu_names[10] = '{"ADD", "SUB", "SLT", "SLTU", "XOR", "OR", "AND", "SLL", "SRL", "SRA"};
  logic [6:0] opcs[9]  = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63};

  exe_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .alu_info(alu_info), .bj_sel(bj_sel),
    .is_word_opt(is_word_opt), .imm(imm), .out_pc(out_pc), .illegal(illegal)
`ifdef ISSUE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic int alu_index(input string nm);
    for (int k = 0; k < 10; k++) if (alu_names[k] == nm) return k;
    return 0;
  endfunction

  // Reference: name the instruction from its fields, then apply the operand rules.
  function automatic exp_t ref_decode(input logic [31:0] i, input logic [63:0] pc,
                                      input logic [63:0] rs1, input logic [63:0] rs2);
    exp_t m;
    string base;
    logic w, ci;
    int bj;
    logic [63:0] a, b, im, ii, iu, ij, ib;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    ii = 64'($signed(i[31:20]));
    iu = 64'($signed({i[31:12], 12'h000}));
    ij = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    ib = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    base = ""; w = 1'b0; ci = 1'b0; bj = -1; a = '0; b = '0; im = '0;
    case (opc)
      7'h33, 7'h3B: begin
        w = (opc == 7'h3B); a = rs1; b = rs2;
        if (f7 == 7'h00 && (!w || f3 inside {3'd0, 3'd1, 3'd5})) base = rr_names[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) base = "SUB";
        else if (f7 == 7'h20 && f3 == 3'd5) base = "SRA";
      end
      7'h13, 7'h1B: begin
        w = (opc == 7'h1B); a = rs1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          b = w ? 64'(i[24:20]) : 64'(i[25:20]);
          if (w ? (f7 == 7'h00) : (i[31:26] == 6'h00)) base = (f3 == 3'd1) ? "SLL" : "SRL";
          else if (f3 == 3'd5 && (w ? (f7 == 7'h20) : (i[31:26] == 6'h10))) base = "SRA";
        end else begin
          b = ii; im = ii; ci = 1'b1;
          if (!w || f3 == 3'd0) base = rr_names[f3];
        end
      end
      7'h37: begin base = "ADD"; b = iu; im = iu; ci = 1'b1; end
      7'h17: begin base = "ADD"; a = pc; b = iu; im = iu; ci = 1'b1; end
      7'h6F: begin base = "ADD"; a = pc; b = 64'd4; bj = 7; im = ij; ci = 1'b1; end
      7'h67: if (f3 == 3'd0) begin base = "ADD"; a = pc; b = 64'd4; bj = 6; im = ii; ci = 1'b1; end
      7'h63: begin
        a = rs1; b = rs2; im = ib; ci = 1'b1;
        case (f3)
          3'd0: begin base = "XOR";  bj = 0; end
          3'd1: begin base = "XOR";  bj = 1; end
          3'd4: begin base = "SLT";  bj = 2; end
          3'd5: begin base = "SLT";  bj = 3; end
          3'd6: begin base = "SLTU"; bj = 4; end
          3'd7: begin base = "SLTU"; bj = 5; end
          default: ;
        endcase
      end
      default: ;
    endcase
    m = '0;
    m.pc = pc;
    if (base == "") begin
      m.ill = 1'b1;
    end else begin
      if (w && base == "SRL") a = 64'(rs1[31:0]);
      if (w && base == "SRA") a = 64'($signed(rs1[31:0]));
      m.op1 = a; m.op2 = b; m.w = w; m.imm = im; m.chk_imm = ci;
      m.alu = 10'(1) << alu_index(base);
      if (bj >= 0) m.bj = 8'(1) << bj;
    end
    return m;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] i;
    i = $urandom();
    if ($urandom_range(0, 10) < 9) i[6:0] = opcs[$urandom_range(0, 8)];
    if ($urandom_range(0, 3) != 0) i[31:26] = ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h00;
    return i;
  endfunction

  task automatic check_payload(input string tag, input exp_t m);
    check({tag, "_op1"}, op1, m.op1);
    check({tag, "_op2"}, op2, m.op2);
    check({tag, "_alu"}, 64'(alu_info), 64'(m.alu));
    check({tag, "_bj"}, 64'(bj_sel), 64'(m.bj));
    check({tag, "_word"}, 64'(is_word_opt), 64'(m.w));
    check({tag, "_pc"}, out_pc, m.pc);
    check({tag, "_illegal"}, 64'(illegal), 64'(m.ill));
    if (m.chk_imm) check({tag, "_imm"}, imm, m.imm);
  endtask

  task automatic offer(input logic [31:0] inst, input logic [63:0] pc,
                       input logic [63:0] r1, input logic [63:0] r2);
    @(negedge clk);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; rs1_data = r1; rs2_data = r2;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_op1", op1, 64'd0);
    check("rst_op2", op2, 64'd0);
    check("rst_alu", 64'(alu_info), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    rst = 1'b1;

    offer(32'h00500093, 64'h1000, 64'd0, 64'd0);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_op1", op1, 64'd0);
    check("addi_op2", op2, 64'd5);
    check("addi_alu", 64'(alu_info), 64'h001);
    check("addi_bj", 64'(bj_sel), 64'd0);
    check("addi_word", 64'(is_word_opt), 64'd0);
    consume();
    check("empty_valid", 64'(out_valid), 64'd0);
    check("empty_hold_op2", op2, 64'd5);

    offer(32'h4020D1BB, 64'h1004, 64'h0000_0000_8000_0000, 64'd3);
    check("sraw_op1", op1, 64'hFFFF_FFFF_8000_0000);
    check("sraw_op2", op2, 64'd3);
    check("sraw_alu", 64'(alu_info), 64'h200);
    check("sraw_word", 64'(is_word_opt), 64'd1);
    consume();

    offer(32'h0020E463, 64'h8000_0000, 64'h11, 64'h22);
    check("bltu_op1", op1, 64'h11);
    check("bltu_op2", op2, 64'h22);
    check("bltu_alu", 64'(alu_info), 64'h008);
    check("bltu_bj", 64'(bj_sel), 64'h10);
    check("bltu_imm", imm, 64'd8);
    check("bltu_pc", out_pc, 64'h8000_0000);
    consume();

    offer(32'h0000_0000, 64'h2000, 64'h55, 64'h66);
    check("ill_flag", 64'(illegal), 64'd1);
    check("ill_alu", 64'(alu_info), 64'd0);
    check("ill_op1", op1, 64'd0);
    consume();

    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready", 64'(in_ready), (k < 2) ? 64'd1 : 64'd0);
      in_valid = 1'b1;
      in_inst = 32'h0000_0093 | (32'(k + 1) << 20);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_first", op2, 64'd1);
    @(negedge clk);
    check("bp_second_valid", 64'(out_valid), 64'd1);
    check("bp_second", op2, 64'd2);
    @(negedge clk);
    check("bp_drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    offer(32'h0070_0093, 64'h3000, 64'd0, 64'd0);
    offer(32'h0080_0093, 64'h3004, 64'd0, 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0090_0093;
    check("flush_cycle_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_no_enq", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    offer(32'h00A0_0093, 64'h4000, 64'd0, 64'd0);
    offer(32'h00B0_0093, 64'h4004, 64'd0, 64'd0);
    check("stall_full", 64'(in_ready), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_ready", 64'(in_ready), 64'd1);
    check("async_rst_op2", op2, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    shown = '0;
    shown.chk_imm = 1'b1;
`ifdef ISSUE_STALL_CNT_EN
    stall_m = '0;
`endif
    for (int c = 0; c < 400; c++) begin
      int n;
      check("rnd_out_valid", 64'(out_valid), (exp_q.size() != 0) ? 64'd1 : 64'd0);
      check("rnd_in_ready", 64'(in_ready), (exp_q.size() < 2) ? 64'd1 : 64'd0);
      check_payload("rnd", shown);
`ifdef ISSUE_STALL_CNT_EN
      check("rnd_stall_cnt", 64'(stall_cnt), 64'(stall_m));
`endif
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_inst   = gen_inst();
      in_pc     = {$urandom(), $urandom()};
      rs1_data  = {$urandom(), $urandom()};
      rs2_data  = {$urandom(), $urandom()};
      @(posedge clk);
      n = exp_q.size();
`ifdef ISSUE_STALL_CNT_EN
      if (n > 0 && !out_ready && stall_m != 32'hFFFF_FFFF) stall_m++;
`endif
      if (flush) begin
        exp_q.delete();
      end else begin
        if (n > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && n < 2) exp_q.push_back(ref_decode(in_inst, in_pc, rs1_data, rs2_data));
      end
      if (exp_q.size() > 0) shown = exp_q[0];
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
